// File: rtl/leaky_relu_inv.sv
// leaky_relu_inv: float32 inverse leaky ReLU (y<0 -> y/|alpha|) with a bit-serial restoring divider
module leaky_relu_inv #(
  parameter int QBITS = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_float,
  input  logic [31:0] coefficient,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_float
);
  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;
  state_t state, state_nx;
  logic [24:0] rem, q;
  logic [23:0] ma;
  logic [7:0] ey, ea;
  logic [4:0] cnt;
  logic byp, ge;
  logic [31:0] byp_val, res;
  logic [24:0] sub;
  logic [22:0] mant;
  logic signed [9:0] e, ex;
  logic [7:0] y_e, a_e;
  assign y_e = in_float[30:23];
  assign a_e = coefficient[30:23];
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    byp = !(in_float[31] && y_e != 8'd0 && y_e != 8'd255 && a_e != 8'd0 && a_e != 8'd255);
    byp_val = !in_float[31] ? in_float :
              (y_e == 8'd255 && in_float[22:0] != 23'd0) ? 32'h7FC00000 :
              y_e == 8'd255 ? 32'hFF800000 :
              y_e == 8'd0 ? 32'h80000000 :
              (a_e == 8'd255 && coefficient[22:0] != 23'd0) ? 32'h7FC00000 :
              a_e == 8'd0 ? 32'hFF800000 :
              a_e == 8'd255 ? 32'h80000000 : 32'h0;
  end
  always_comb begin
    ge = rem >= {1'b0, ma};
    sub = rem - {1'b0, ma};
    e = $signed({2'b00, ey}) - $signed({2'b00, ea}) + 10'sd127;
    ex = q[24] ? e : e - 10'sd1;
    mant = q[24] ? q[23:1] : q[22:0];
    res = ex >= 10'sd255 ? 32'hFF800000 :
          ex <= 10'sd0 ? 32'h80000000 : {1'b1, ex[7:0], mant};
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = in_valid ? (byp ? DONE : DIV) : IDLE;
      DIV:  state_nx = cnt == 5'(QBITS - 1) ? NORM : DIV;
      NORM: state_nx = DONE;
      DONE: state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out_float <= 32'h0;
      rem <= '0;
      q <= '0;
      ma <= '0;
      ey <= '0;
      ea <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        if (byp) out_float <= byp_val;
        rem <= {2'b01, in_float[22:0]};
        ma <= {1'b1, coefficient[22:0]};
        ey <= y_e;
        ea <= a_e;
        q <= '0;
        cnt <= '0;
      end
      if (state == DIV) begin
        rem <= (ge ? sub : rem) << 1;
        q <= {q[23:0], ge};
        cnt <= cnt + 5'd1;
      end
      if (state == NORM) out_float <= res;
    end
  end
endmodule

// File: tb/tb_leaky_relu_inv.sv
// tb_leaky_relu_inv: randomized and directed checks of leaky_relu_inv against an arithmetic reference
module tb_leaky_relu_inv;
  logic clk = 0, rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_float, coefficient, out_float;
  int errors = 0, checks = 0;

  leaky_relu_inv dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_float(in_float), .coefficient(coefficient), .out_valid(out_valid),
    .out_ready(out_ready), .out_float(out_float)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic is_div(input logic [31:0] y, input logic [31:0] a);
    return y[31] && y[30:23] != 0 && y[30:23] != 255 && a[30:23] != 0 && a[30:23] != 255;
  endfunction

  // x = y / |alpha| with the quotient truncated to 25 significant bits
  function automatic logic [31:0] ref_model(input logic [31:0] y, input logic [31:0] a);
    logic [47:0] num, den, q;
    logic [22:0] mant;
    int e;
    if (!y[31]) return y;
    if (y[30:23] == 255 && y[22:0] != 0) return 32'h7FC00000;
    if (y[30:23] == 255) return 32'hFF800000;
    if (y[30:23] == 0) return 32'h80000000;
    if (a[30:23] == 255 && a[22:0] != 0) return 32'h7FC00000;
    if (a[30:23] == 0) return 32'hFF800000;
    if (a[30:23] == 255) return 32'h80000000;
    num = {24'd0, 1'b1, y[22:0]} << 24;
    den = {24'd0, 1'b1, a[22:0]};
    q = num / den;
    e = int'(y[30:23]) - int'(a[30:23]) + 127;
    if (q < 48'h1000000) begin
      e--;
      mant = q[22:0];
    end else mant = q[23:1];
    if (e >= 255) return 32'hFF800000;
    if (e <= 0) return 32'h80000000;
    return {1'b1, e[7:0], mant};
  endfunction

  // Issue one operand at a negedge, measure latency, optionally stall, then complete the transfer
  task automatic do_op(input logic [31:0] y, input logic [31:0] a, input int hold);
    int lat;
    logic [31:0] held;
    check("in_ready_before", {31'd0, in_ready}, 32'd1);
    out_ready = (hold == 0);
    in_float = y;
    coefficient = a;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    in_float = $urandom;
    coefficient = $urandom;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, is_div(y, a) ? 32'd27 : 32'd1);
    check("result", out_float, ref_model(y, a));
    held = out_float;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1;
      in_float = 32'hBF800000;
      coefficient = 32'h3F000000;
      @(negedge clk);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_data", out_float, held);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    check("valid_drop", {31'd0, out_valid}, 32'd0);
    check("ready_return", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst = 1;
    in_valid = 0;
    out_ready = 1;
    in_float = 0;
    coefficient = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_float", out_float, 32'h0);

    do_op(32'h40000000, 32'h3DCCCCCD, 0);
    do_op(32'hBF800000, 32'h3F000000, 0);
    check("neg1_div_half", out_float, 32'hC0000000);
    do_op(32'hBF800000, 32'h3DCCCCCD, 0);
    check("truncation", out_float, 32'hC11FFFFF);
    do_op(32'hFE000000, 32'h3C000000, 0);
    check("overflow", out_float, 32'hFF800000);
    do_op(32'hFFC00001, 32'h3DCCCCCD, 0);
    do_op(32'h80000000, 32'h3DCCCCCD, 0);
    do_op(32'hBF800000, 32'h00000000, 0);
    do_op(32'hFF800000, 32'h3DCCCCCD, 0);
    do_op(32'hBF800000, 32'h7F800000, 0);
    do_op(32'hBF800000, 32'h7FC00000, 0);
    do_op(32'h80800000, 32'h42C80000, 0);

    do_op(32'hC0400000, 32'h3E800000, 10);
    do_op(32'hBF800000, 32'h3F000000, 0);

    // abort a divide partway through; nothing from it may surface
    in_float = 32'hC0400000;
    coefficient = 32'h3DCCCCCD;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (11) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_out_float", out_float, 32'h0);
    begin
      logic stale = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (out_valid) stale = 1;
      end
      check("no_stale", {31'd0, stale}, 32'd0);
    end
    do_op(32'hBF800000, 32'h3F000000, 0);
    check("after_rst", out_float, 32'hC0000000);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] y, a;
      y = $urandom;
      a = $urandom;
      if (n % 4 != 0) begin
        y = {1'b1, 8'($urandom_range(1, 254)), 23'($urandom)};
        a = {1'($urandom), 8'($urandom_range(90, 160)), 23'($urandom)};
      end
      do_op(y, a, (n % 7 == 3) ? 2 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
